seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder.sv | 140 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: ripples CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed-overflow output enabled by defining SEQ_ADD_SIGNED_OVF_EN.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SEQ_ADD_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               cy_q;
    logic [WIDTH-1:0]   psum_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;
`ifdef SEQ_ADD_SIGNED_OVF_EN
    logic               ovf_q;
    logic               slice_cmsb_c;
`endif

    logic [CHUNK-1:0]   slice_sum_c;
    logic               slice_cout_c;
    logic [WIDTH-1:0]   psum_d;

    // Operands shift down one chunk per cycle, so the slice always reads the low chunk.
    always_comb begin
        logic c;
        c           = cy_q;
        slice_sum_c = '0;
`ifdef SEQ_ADD_SIGNED_OVF_EN
        slice_cmsb_c = 1'b0;
`endif
        for (int unsigned i = 0; i < CHUNK; i++) begin
`ifdef SEQ_ADD_SIGNED_OVF_EN
            if (i == CHUNK - 1) begin
                slice_cmsb_c = c;
            end
`endif
            slice_sum_c[i] = a_q[i] ^ b_q[i] ^ c;
            c              = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_cout_c = c;
    end

    // Each new chunk enters at the top; after N cycles the first chunk has reached bit 0.
    always_comb begin
        psum_d = (psum_q >> CHUNK) | (WIDTH'(slice_sum_c) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_ADD_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        cy_q    <= cin;
                        idx_q   <= '0;
                        psum_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ADD: begin
                    a_q    <= a_q >> CHUNK;
                    b_q    <= b_q >> CHUNK;
                    cy_q   <= slice_cout_c;
                    psum_q <= psum_d;
                    idx_q  <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        sum_q   <= psum_d;
                        cout_q  <= slice_cout_c;
`ifdef SEQ_ADD_SIGNED_OVF_EN
                        ovf_q   <= slice_cout_c ^ slice_cmsb_c;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = cout_q;
`ifdef SEQ_ADD_SIGNED_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder (WIDTH=32, CHUNK=4): stimulus pushes expectations, monitor pops on done.
module tb_seq_chunk_adder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 4;
    localparam int unsigned N     = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SEQ_ADD_SIGNED_OVF_EN
    logic             ovf;
`endif

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SEQ_ADD_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        logic [WIDTH:0] t;
        exp_t           e;
        t   = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        e.s = t[WIDTH-1:0];
        e.c = t[WIDTH];
        e.o = (x[WIDTH-1] == y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        return e;
    endfunction

    // Pops one expectation per done pulse; a done with nothing queued is itself an error.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("sum", 64'(sum), 64'(e.s));
                    check("carry", 64'(carry), 64'(e.c));
`ifdef SEQ_ADD_SIGNED_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.o));
`endif
                end
            end
        end
    endtask

    // Drives one accepted request; returns #1 after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci, input exp_t e);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = ci;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt);
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        if (!done) check("done_timeout", 64'(done), 64'(1));
    endtask

    initial begin
        int edges;
        int bcnt;
        int ndone;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_carry", 64'(carry), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Wrap-around: all-ones + 1
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
        wait_done(edges, bcnt);
        check("t1_latency", 64'(edges), 64'(N));
        check("t1_busy_cycles", 64'(bcnt), 64'(N));
        check("t1_busy_at_done", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", 64'(done), 64'(0));

        // Previous result holds through the next ADD phase
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, mk(32'hACF1_3569, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("t2_hold_sum", 64'(sum), 64'(32'h0000_0000));
        check("t2_hold_carry", 64'(carry), 64'(1));
        check("t2_busy_mid", 64'(busy), 64'(1));
        wait_done(edges, bcnt);
        check("t2_latency", 64'(edges), 64'(N - 3));
        repeat (4) @(posedge clk);
        #1;
        check("t2_hold_idle", 64'(sum), 64'(32'hACF1_3569));

        // start held high: accepts every N+1 edges, operands sampled only then
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            start = 1'b1;
            a     = 32'h0F0F_0F0F + 32'(k) * 32'h0101_0101;
            b     = 32'hF000_0000 ^ (32'(k) * 32'h1111_1111);
            cin   = 1'(k % 2);
            if (k % 9 == 0) sb.push_back(model(a, b, cin));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t3_drained", 64'(sb.size()), 64'(0));

        // start during ADD is ignored
        start_op(32'h0000_0100, 32'h0000_0200, 1'b0, mk(32'h0000_0300, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("t4_single_done", 64'(ndone), 64'(1));
        check("t4_sum", 64'(sum), 64'(32'h0000_0300));

        // Asynchronous reset mid-operation
        start_op(32'hAAAA_5555, 32'h1234_5678, 1'b1, mk(32'hBCDE_ABCE, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_done", 64'(done), 64'(0));
        check("t5_rst_sum", 64'(sum), 64'(0));
        check("t5_rst_carry", 64'(carry), 64'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        start_op(32'd5, 32'd7, 1'b0, mk(32'd12, 1'b0, 1'b0));
        wait_done(edges, bcnt);
        check("t5_latency", 64'(edges), 64'(N));

`ifdef SEQ_ADD_SIGNED_OVF_EN
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
        wait_done(edges, bcnt);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1));
        wait_done(edges, bcnt);
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
        wait_done(edges, bcnt);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
